// File: rtl/tonegen_write_master.sv
// tonegen_write_master
//   Purpose : host-side initiator for the tone generator register bus. Commands
//             arrive on a valid/ready port and queue in a small circular FIFO.
//             They are replayed one at a time as an address/data setup phase,
//             a stretched write strobe, and an address/data hold phase.
//   Ports   : clk/rst_n (async, active low); ena gates the start of new writes;
//             cmd_valid/cmd_ready/cmd_addr/cmd_data form the command input;
//             address_out/data_out/write_strobe_out drive the tone generator;
//             busy and fifo_level report status.
//   Latency : a push into an empty, idle block reaches address_out/data_out on
//             the next edge. The strobe rises SETUP_CYCLES later.
//             Each write occupies 1+SETUP+STROBE+HOLD cycles.
module tonegen_write_master #(
   parameter int FIFO_DEPTH    = 4,
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 52,
   parameter int HOLD_CYCLES   = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [2:0]                    cmd_addr,
   input  logic [4:0]                    cmd_data,
   output logic [2:0]                    address_out,
   output logic [4:0]                    data_out,
   output logic                          write_strobe_out,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PW      = $clog2(FIFO_DEPTH);
   localparam int LW      = PW + 1;
   localparam int CNT_MAX = (SETUP_CYCLES > STROBE_CYCLES)
                          ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                          : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              cnt_zero;

   logic [7:0]        mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [LW-1:0]     level;
   logic              push, pop, full, empty;

   // ---------------- command FIFO ----------------
   // Ready depends only on the current level: a full FIFO refuses a push even
   // on an edge where it is also popping.
   assign full      = (level == LW'(FIFO_DEPTH));
   assign empty     = (level == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   // A pop only happens from IDLE with data already present, so a push into
   // an empty FIFO is never popped on the same edge.
   assign pop       = (state == IDLE) && ena && !empty;
   assign fifo_level = level;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_addr, cmd_data};
      end
   end

   // Pointers are PW bits wide and FIFO_DEPTH is a power of two, so the
   // natural overflow of the increment implements the wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   assign cnt_zero = (cnt == '0);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pop)      state_nxt = SETUP;
         SETUP:   if (cnt_zero) state_nxt = STROBE;
         STROBE:  if (cnt_zero) state_nxt = HOLD;
         HOLD:    if (cnt_zero) state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // The strobe is decoded from the registered state, so it rises and falls
   // on clock edges and drops as soon as reset forces the state to IDLE.
   always_comb begin
      write_strobe_out = (state == STROBE);
      busy             = (state != IDLE) || !empty;
   end

   // ---------------- shared phase counter ----------------
   // Each phase loads its length minus one on entry and counts down to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         case (state)
            IDLE:    if (pop) cnt <= CNT_W'(SETUP_CYCLES - 1);
            SETUP:   cnt <= cnt_zero ? CNT_W'(STROBE_CYCLES - 1) : cnt - CNT_W'(1);
            STROBE:  cnt <= cnt_zero ? CNT_W'(HOLD_CYCLES - 1)   : cnt - CNT_W'(1);
            HOLD:    cnt <= cnt_zero ? '0 : cnt - CNT_W'(1);
            default: cnt <= '0;
         endcase
      end
   end

   // ---------------- address/data registers ----------------
   // Loaded only when a command is popped; they hold through SETUP, STROBE,
   // HOLD and the following IDLE time, giving setup and hold margin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         address_out <= '0;
         data_out    <= '0;
      end else if (pop) begin
         address_out <= mem[rd_ptr][7:5];
         data_out    <= mem[rd_ptr][4:0];
      end
   end

endmodule

// File: doc/tonegen_write_master.md
Name: tonegen_write_master

Overview:
- Host-side initiator for the tone generator's register write bus (3-bit address, 5-bit data, write strobe).
- Queues register-write commands from a valid/ready source in a small FIFO and replays them one at a time.
- Drives address/data with setup and hold margins, and stretches the strobe so the signal generator reliably samples every write in its slower scaled-clock domain.
- Sits in the fast clk domain, upstream of the tone generator top.

Parameters:
- FIFO_DEPTH, 4, command queue entries; power of two, >= 2.
- SETUP_CYCLES, 2, clk cycles that address/data are stable before the strobe rises; >= 1.
- STROBE_CYCLES, 52, clk cycles the strobe stays high; covers >= 1 full scaled-clock period (scale 25 -> period 50); >= 1.
- HOLD_CYCLES, 2, clk cycles that address/data stay stable after the strobe falls; >= 1.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- ena, input, 1, design enable; gates the start of new transactions.
- cmd_valid, input, 1, a command is offered.
- cmd_ready, output, 1, the FIFO can accept a command.
- cmd_addr, input, 3, register address of the offered command.
- cmd_data, input, 5, register data of the offered command.
- address_out, output, 3, to the tone generator address_in.
- data_out, output, 5, to the tone generator data_in.
- write_strobe_out, output, 1, to the tone generator write_strobe_in.
- busy, output, 1, a transaction is in flight or the FIFO is non-empty.
- fifo_level, output, clog2(FIFO_DEPTH)+1, number of queued commands.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO is emptied; state = IDLE; counter = 0.
  - address_out = 0, data_out = 0, write_strobe_out = 0, busy = 0, fifo_level = 0, cmd_ready = 1.
  - Asserting reset mid-transaction drops the strobe immediately and discards all queued commands.
- Input handshake:
  - A push happens on a clk edge where cmd_valid && cmd_ready.
  - cmd_ready = !full. It depends only on the current level, so a push is refused when the FIFO is full even on the same edge as a pop.
  - cmd_valid while full: the command is not taken; no error flag is raised. The source must hold it.
- FSM states: IDLE, SETUP, STROBE, HOLD. A single down-counter is shared across states.
  - IDLE: if ena && FIFO non-empty, then at the edge: pop the head, load address_out/data_out, counter = SETUP_CYCLES-1, go to SETUP. Otherwise stay in IDLE.
  - SETUP: strobe low. When counter = 0: strobe goes high, counter = STROBE_CYCLES-1, go to STROBE. Otherwise decrement.
  - STROBE: strobe high. When counter = 0: strobe goes low, counter = HOLD_CYCLES-1, go to HOLD. Otherwise decrement.
  - HOLD: strobe low. When counter = 0: go to IDLE. Otherwise decrement.
- Output stability:
  - address_out and data_out change only on the IDLE->SETUP edge.
  - Both retain their last values while in IDLE.
- Timing:
  - Strobe is high for exactly STROBE_CYCLES cycles.
  - From a push on edge N into an empty FIFO with the FSM in IDLE: outputs update at edge N+1; strobe rises at N+1+SETUP_CYCLES; strobe falls at N+1+SETUP_CYCLES+STROBE_CYCLES; FSM returns to IDLE HOLD_CYCLES later.
  - Back-to-back commands: each occupies 1+SETUP+STROBE+HOLD cycles, i.e. 57 with the defaults.
  - The strobe is never high on two consecutive transactions without at least HOLD_CYCLES+1+SETUP_CYCLES low cycles between them.
- ena:
  - ena low blocks only the IDLE->SETUP transition.
  - A transaction already in flight completes unchanged.
  - Pushes are still accepted while ena is low.
- FIFO:
  - Circular buffer with clog2(FIFO_DEPTH)-bit pointers that wrap at FIFO_DEPTH.
  - Simultaneous push and pop when not full: level unchanged, both pointers advance.
  - A push into an empty FIFO cannot pop on the same edge; the pop occurs on the next edge at the earliest.
  - Preserves FIFO order.
- busy = (state != IDLE) || (fifo_level != 0). Combinational from registered state.

Test Plan:
- Reset, then push addr=3, data=0x15 with ena=1 -> address_out=3 and data_out=0x15 one cycle after the push; strobe high for exactly 52 cycles starting 2 cycles later; busy low 57 cycles after the push edge.
- Push 5 commands back-to-back with FIFO_DEPTH=4 while ena=0 -> first 4 accepted, cmd_ready low, fifo_level=4, the 5th held. Raise ena -> the 5th is accepted one cycle after the first pop; all 5 are issued in order, with strobes 57 cycles apart.
- Push (1,0x01) then (2,0x1F) -> address_out/data_out remain constant throughout each SETUP/STROBE/HOLD window; they change only at the IDLE->SETUP edge.
- Drop ena during the STROBE of the first of two queued commands -> the first completes normally (52-cycle strobe); the second stays queued (fifo_level=1, busy=1) until ena returns high.
- Assert rst_n low at cycle 20 of a strobe with 3 commands queued -> strobe, address_out, data_out and fifo_level go to 0 immediately; after release, no writes are issued.
- Fill the FIFO, drain it, and refill 3 times (pointer wrap) -> 12 writes observed, in order, with no duplicates or losses.
